superscalar_reservation_station: RTL
====================================

Name: superscalar_reservation_station

Overview:
- Per-functional-unit reservation station for the 3-way Tomasulo core; one instance sits directly upstream of each execute-stage FU.
- Buffers dispatched ops and captures missing operands by snooping the 3-port Common Data Bus (CDB).
- Issues the oldest fully-ready op to its FU via a valid/ready handshake.
- Issue-side signals map 1:1 onto the FU side of rs_to_exec_if: data_a, data_b, control_signals, pc, branch_sel, branch_prediction, issue_ready.

Parameters:
- DATA_WIDTH, 32, operand/result width
- DEPTH, 4, number of entries (2..8)
- TAG_WIDTH, 5, ROB tag width
- CTRL_WIDTH, 11, control_signals width; [10:7] func_sel, [5] save-PC
- NUM_CDB, 3, CDB broadcast ports

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush (mispredict); synchronous clear of all entries
- dispatch_valid  in  1  dispatch request
- dispatch_ready  out  1  at least one free entry
- dispatch_control_signals  in  CTRL_WIDTH  op control
- dispatch_pc  in  DATA_WIDTH  instruction PC
- dispatch_branch_sel  in  3  branch type
- dispatch_branch_prediction  in  1  predicted taken
- dispatch_rd_tag  in  TAG_WIDTH  destination ROB tag
- dispatch_a_ready / dispatch_b_ready  in  1 each  operand value present
- dispatch_a_data / dispatch_b_data  in  DATA_WIDTH each  operand value if ready
- dispatch_a_tag / dispatch_b_tag  in  TAG_WIDTH each  producer tag if not ready
- cdb_valid  in  NUM_CDB  per-port broadcast valid
- cdb_tag  in  NUM_CDB*TAG_WIDTH  packed; port i at [i*TAG_WIDTH +: TAG_WIDTH]
- cdb_data  in  NUM_CDB*DATA_WIDTH  packed; same packing
- issue_valid  out  1  an op is presented
- issue_ready  in  1  FU accepts (FU issue_ready)
- issue_data_a / issue_data_b  out  DATA_WIDTH each  operands
- issue_control_signals  out  CTRL_WIDTH
- issue_pc  out  DATA_WIDTH
- issue_branch_sel  out  3
- issue_branch_prediction  out  1
- issue_rd_tag  out  TAG_WIDTH
- occupancy  out  $clog2(DEPTH+1)  valid entry count

Behaviour:
- Storage is an age-ordered collapsing queue: entry 0 is oldest, new ops append at index = occupancy.
- Each entry holds valid, a_rdy, a_val, a_tag, b_rdy, b_val, b_tag, ctrl, pc, bsel, bpred, rd_tag.
- Reset or flush: all valid=0 next cycle; occupancy=0; issue_valid=0; dispatch_ready=1. Issue-side data outputs are don't-care while issue_valid=0 and must not be checked.
- Flush has priority over dispatch and issue in the same cycle; both are dropped.
- dispatch_ready = (occupancy < DEPTH), from registered state only. A slot freed by issue is reusable the next cycle, not the same cycle.
- Dispatch accept = dispatch_valid && dispatch_ready.
- Dispatch-time CDB capture: if an operand is not ready and its tag matches any valid CDB port in the same cycle, the entry is written with rdy=1 and val=cdb_data.
- Wakeup: every cycle, each valid entry with rdy=0 compares its tag against all NUM_CDB ports. On a match it sets rdy=1 and val=cdb_data at the edge.
- Multiple ports matching one tag: lowest port index wins. This is illegal upstream; assertion only.
- Issue select (combinational): lowest-index entry with valid && a_rdy && b_rdy. issue_valid=1 iff such an entry exists; outputs drive that entry's fields.
- Issue handshake: the entry retires at the edge when issue_valid && issue_ready. Younger entries shift down one slot, with any same-cycle wakeup applied during the shift.
- Simultaneous dispatch + issue: the new op lands at index occupancy-1. Occupancy is unchanged.
- issue_valid may drop without a handshake only on flush or reset.
- Latency:
  - Op dispatched with both operands ready: issue_valid in cycle N+1.
  - Operand woken by CDB in cycle N: issue_valid in N+1.
- Reset asserted mid-operation discards all entries; no partial state survives.

Optional Feature:
- Macro: RS_CDB_ISSUE_BYPASS_EN
- Defined: an entry whose only missing operand(s) match a valid CDB port in the current cycle counts as ready for selection in that same cycle. The issue output muxes cdb_data in place of the stored value. Wakeup-to-issue latency is 0 cycles. The age-priority rule is unchanged.
- Undefined: operands are stored first, so issue occurs no earlier than the cycle after the CDB match.

Test Plan:
- Reset, then dispatch op with a=5, b=7 ready, rd_tag=3, issue_ready=1 -> cycle+1: issue_valid=1, data_a=5, data_b=7, rd_tag=3; next cycle occupancy=0.
- Dispatch op with a waiting on tag 9, b=1; two cycles later cdb_valid=3'b010, port1 tag=9, data=0x1234 -> next cycle issue_valid=1, data_a=0x1234. With RS_CDB_ISSUE_BYPASS_EN: issue_valid=1 in the broadcast cycle.
- Fill 4 entries, issue_ready=0 -> dispatch_ready=0, occupancy=4. Raise issue_ready for 1 cycle -> occupancy=3, dispatch_ready=1 the following cycle, not the same cycle.
- Entries 0 (waiting tag 2) and 1 (ready); broadcast tag 2 on port 2 -> entry 1 issues first; entry 0 (oldest) issues the cycle after with the captured value.
- Dispatch op whose a_tag=4 coincides with a port0 broadcast of tag 4, data 0xAA -> entry stored ready, issues next cycle with data_a=0xAA.
- 3 entries valid, assert flush together with dispatch_valid -> next cycle occupancy=0, issue_valid=0, flushed op not stored.

Source files
------------

// File: rtl/superscalar_reservation_station.sv
// Age-ordered reservation station snooping the CDB; optional RS_CDB_ISSUE_BYPASS_EN lets a same-cycle wakeup issue.
// Latency: ready dispatch -> issue_valid next cycle; CDB wakeup -> issue next cycle (same cycle with bypass).
// Backpressure: dispatch_ready drops when full (registered); the issued entry holds until issue_ready.
module superscalar_reservation_station #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int TAG_WIDTH  = 5,
  parameter int CTRL_WIDTH = 11,
  parameter int NUM_CDB    = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush,
  input  logic                            dispatch_valid,
  output logic                            dispatch_ready,
  input  logic [CTRL_WIDTH-1:0]           dispatch_control_signals,
  input  logic [DATA_WIDTH-1:0]           dispatch_pc,
  input  logic [2:0]                      dispatch_branch_sel,
  input  logic                            dispatch_branch_prediction,
  input  logic [TAG_WIDTH-1:0]            dispatch_rd_tag,
  input  logic                            dispatch_a_ready,
  input  logic                            dispatch_b_ready,
  input  logic [DATA_WIDTH-1:0]           dispatch_a_data,
  input  logic [DATA_WIDTH-1:0]           dispatch_b_data,
  input  logic [TAG_WIDTH-1:0]            dispatch_a_tag,
  input  logic [TAG_WIDTH-1:0]            dispatch_b_tag,
  input  logic [NUM_CDB-1:0]              cdb_valid,
  input  logic [NUM_CDB*TAG_WIDTH-1:0]    cdb_tag,
  input  logic [NUM_CDB*DATA_WIDTH-1:0]   cdb_data,
  output logic                            issue_valid,
  input  logic                            issue_ready,
  output logic [DATA_WIDTH-1:0]           issue_data_a,
  output logic [DATA_WIDTH-1:0]           issue_data_b,
  output logic [CTRL_WIDTH-1:0]           issue_control_signals,
  output logic [DATA_WIDTH-1:0]           issue_pc,
  output logic [2:0]                      issue_branch_sel,
  output logic                            issue_branch_prediction,
  output logic [TAG_WIDTH-1:0]            issue_rd_tag,
  output logic [$clog2(DEPTH+1)-1:0]      occupancy
);
  localparam int OW = $clog2(DEPTH+1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);

  typedef struct packed {
    logic                  valid;
    logic                  a_rdy;
    logic [DATA_WIDTH-1:0] a_val;
    logic [TAG_WIDTH-1:0]  a_tag;
    logic                  b_rdy;
    logic [DATA_WIDTH-1:0] b_val;
    logic [TAG_WIDTH-1:0]  b_tag;
    logic [CTRL_WIDTH-1:0] ctrl;
    logic [DATA_WIDTH-1:0] pc;
    logic [2:0]            bsel;
    logic                  bpred;
    logic [TAG_WIDTH-1:0]  rd_tag;
  } entry_t;

  // Lowest CDB port wins when several match (illegal upstream, see assertion).
  function automatic logic [DATA_WIDTH:0] snoop(
    input logic                          rdy,
    input logic [DATA_WIDTH-1:0]         val,
    input logic [TAG_WIDTH-1:0]          tag,
    input logic [NUM_CDB-1:0]            cv,
    input logic [NUM_CDB*TAG_WIDTH-1:0]  ct,
    input logic [NUM_CDB*DATA_WIDTH-1:0] cd
  );
    logic [DATA_WIDTH:0] r;
    r = {rdy, val};
    if (!rdy) begin
      for (int p = NUM_CDB-1; p >= 0; p--) begin
        if (cv[p] && ct[p*TAG_WIDTH +: TAG_WIDTH] == tag) r = {1'b1, cd[p*DATA_WIDTH +: DATA_WIDTH]};
      end
    end
    return r;
  endfunction

  entry_t           entry_q [DEPTH];
  entry_t           entry_d [DEPTH];
  entry_t           woke    [DEPTH+1];
  entry_t           new_e;
  logic [OW-1:0]    occ_q, occ_d, wr_idx;
  logic [DEPTH-1:0] can_issue;
  logic [IW-1:0]    sel;
  logic             fire, acc, cdb_dup;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      woke[k] = entry_q[k];
      if (entry_q[k].valid) begin
        {woke[k].a_rdy, woke[k].a_val} = snoop(entry_q[k].a_rdy, entry_q[k].a_val, entry_q[k].a_tag,
                                               cdb_valid, cdb_tag, cdb_data);
        {woke[k].b_rdy, woke[k].b_val} = snoop(entry_q[k].b_rdy, entry_q[k].b_val, entry_q[k].b_tag,
                                               cdb_valid, cdb_tag, cdb_data);
      end
    end
    woke[DEPTH] = '0;
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
`ifdef RS_CDB_ISSUE_BYPASS_EN
      can_issue[k] = woke[k].valid && woke[k].a_rdy && woke[k].b_rdy;
`else
      can_issue[k] = entry_q[k].valid && entry_q[k].a_rdy && entry_q[k].b_rdy;
`endif
    end
  end

  always_comb begin
    sel         = '0;
    issue_valid = 1'b0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      if (can_issue[k]) begin
        sel         = IW'(k);
        issue_valid = 1'b1;
      end
    end
  end

  // A selected entry's stored operands equal its woken ones unless bypass supplied them.
  assign issue_data_a            = woke[sel].a_val;
  assign issue_data_b            = woke[sel].b_val;
  assign issue_control_signals   = woke[sel].ctrl;
  assign issue_pc                = woke[sel].pc;
  assign issue_branch_sel        = woke[sel].bsel;
  assign issue_branch_prediction = woke[sel].bpred;
  assign issue_rd_tag            = woke[sel].rd_tag;

  assign dispatch_ready = occ_q < DEPTH_C;
  assign occupancy      = occ_q;
  assign fire           = issue_valid && issue_ready;
  assign acc            = dispatch_valid && dispatch_ready;
  assign wr_idx         = occ_q - OW'(fire);

  always_comb begin
    new_e        = '0;
    new_e.valid  = 1'b1;
    {new_e.a_rdy, new_e.a_val} = snoop(dispatch_a_ready, dispatch_a_data, dispatch_a_tag,
                                       cdb_valid, cdb_tag, cdb_data);
    {new_e.b_rdy, new_e.b_val} = snoop(dispatch_b_ready, dispatch_b_data, dispatch_b_tag,
                                       cdb_valid, cdb_tag, cdb_data);
    new_e.a_tag  = dispatch_a_tag;
    new_e.b_tag  = dispatch_b_tag;
    new_e.ctrl   = dispatch_control_signals;
    new_e.pc     = dispatch_pc;
    new_e.bsel   = dispatch_branch_sel;
    new_e.bpred  = dispatch_branch_prediction;
    new_e.rd_tag = dispatch_rd_tag;
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      entry_d[k] = (fire && k >= int'(sel)) ? woke[k+1] : woke[k];
      if (acc && wr_idx == OW'(k)) entry_d[k] = new_e;
    end
    occ_d = occ_q + OW'(acc) - OW'(fire);
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      occ_q <= '0;
      for (int k = 0; k < DEPTH; k++) entry_q[k] <= '0;
    end else begin
      occ_q <= occ_d;
      for (int k = 0; k < DEPTH; k++) entry_q[k] <= entry_d[k];
    end
  end

  always_comb begin
    cdb_dup = 1'b0;
    for (int i = 0; i < NUM_CDB; i++) begin
      for (int j = i + 1; j < NUM_CDB; j++) begin
        if (cdb_valid[i] && cdb_valid[j] &&
            cdb_tag[i*TAG_WIDTH +: TAG_WIDTH] == cdb_tag[j*TAG_WIDTH +: TAG_WIDTH]) cdb_dup = 1'b1;
      end
    end
  end

  assert property (@(posedge clk) disable iff (reset) !cdb_dup);

endmodule
